mcu_ram_avalon_pipe: RTL and testbench

//  Avalon-MM pipeline stage directly upstream of the on-chip RAM slave (mcu_ram).

---
 rtl/mcu_ram_avalon_pipe.sv | 153 +++++++++++++++
 tb/tb_mcu_ram_avalon_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_ram_avalon_pipe.sv
// rtl/mcu_ram_avalon_pipe.sv - Avalon-MM command-queue pipeline stage in front of the mcu_ram slave
// Optional MCU_RAM_PIPE_RANGE_CHECK_EN: out-of-range commands never reach the RAM and set err_sticky.
`timescale 1ns/1ps

module mcu_ram_avalon_pipe_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full_next
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Callers never push while full nor pop while empty; the pointers wrap naturally at DEPTH.
  assign count_next = count + CW'(push) - CW'(pop);
  assign full_next  = (count_next == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

module mcu_ram_avalon_pipe #(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 51200,
  parameter int CMD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [3:0]        s_byteenable,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic              s_waitrequest,
  output logic [31:0]       s_readdata,
  output logic              s_readdatavalid,
  input  logic              hold,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
  input  logic [31:0]       m_readdata,
  output logic              err_sticky
);

  localparam int CMD_W = ADDR_W + 4 + 32 + 1;

`ifdef MCU_RAM_PIPE_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic              accept;
  logic              issue;
  logic              fifo_empty;
  logic              fifo_full_next;
  logic [CMD_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [3:0]        head_be;
  logic [31:0]       head_wdata;
  logic              head_is_write;
  logic              head_oor;
  logic              rd_pend;
  logic              rd_pend_oor;

  // A simultaneous read+write is queued as a write; the read is dropped.
  assign accept = (s_read | s_write) & ~s_waitrequest;
  assign issue  = ~fifo_empty & ~hold;

  mcu_ram_avalon_pipe_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data ({s_address, s_byteenable, s_writedata, s_write}),
    .pop       (issue),
    .head      (head),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  assign {head_addr, head_be, head_wdata, head_is_write} = head;
  assign head_oor = RANGE_CHECK && (32'(head_addr) >= 32'(DEPTH));

  assign m_address    = head_addr;
  assign m_byteenable = head_be;
  assign m_writedata  = head_wdata;
  assign m_chipselect = issue & ~head_oor;
  assign m_write      = issue & ~head_oor & head_is_write;
  assign m_clken      = ~hold;

  // RAM data is valid the cycle after issue; it is captured then, independent of hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_waitrequest   <= 1'b1;
      rd_pend         <= 1'b0;
      rd_pend_oor     <= 1'b0;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_waitrequest   <= fifo_full_next;
      rd_pend         <= issue & ~head_is_write;
      rd_pend_oor     <= issue & ~head_is_write & head_oor;
      s_readdatavalid <= rd_pend;
      if (rd_pend) s_readdata <= rd_pend_oor ? 32'hDEAD_BEEF : m_readdata;
    end
  end

`ifdef MCU_RAM_PIPE_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               err_sticky <= 1'b0;
    else if (issue && head_oor) err_sticky <= 1'b1;
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_ram_avalon_pipe.sv
// tb/tb_mcu_ram_avalon_pipe.sv - randomized self-checking bench for mcu_ram_avalon_pipe
`timescale 1ns/1ps

module tb_mcu_ram_avalon_pipe;

  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 51200;
  localparam int CMD_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] s_address = '0;
  logic [3:0]        s_byteenable = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [31:0]       s_writedata = '0;
  logic              s_waitrequest;
  logic [31:0]       s_readdata;
  logic              s_readdatavalid;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic              m_clken;
  logic [31:0]       m_readdata = '0;
  logic              err_sticky;

  always #5 clk = ~clk;

  mcu_ram_avalon_pipe #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .CMD_DEPTH (CMD_DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_address       (s_address),
    .s_byteenable    (s_byteenable),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .hold            (hold),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_clken         (m_clken),
    .m_readdata      (m_readdata),
    .err_sticky      (err_sticky)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cs_oor = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit out_of_range(input int a);
`ifdef MCU_RAM_PIPE_RANGE_CHECK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // RAM stand-in: synchronous 1-cycle read, byte-enabled write, frozen when clken low
  logic [31:0] ram [int];
  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write)
        ram[int'(m_address)] = merge(ram.exists(int'(m_address)) ? ram[int'(m_address)] : 32'h0,
                                     m_writedata, m_byteenable);
      else
        m_readdata <= ram.exists(int'(m_address)) ? ram[int'(m_address)] : 32'h0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image as seen by the master plus in-order expected responses
  logic [31:0] gold [int];
  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;
  exp_t expq[$];
  exp_t e_mon;

  function automatic logic [31:0] gold_rd(input int a);
    return gold.exists(a) ? gold[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (reset_n && s_readdatavalid) begin
      if (expq.size() == 0) check("spurious_rdv", 32'd1, 32'd0);
      else begin
        e_mon = expq.pop_front();
        check("rdata", s_readdata, e_mon.data);
        if (e_mon.lat != 0) check("latency", 32'(cyc - e_mon.acc), 32'(e_mon.lat));
      end
    end
    if (reset_n) check("clken", {31'd0, m_clken}, {31'd0, ~hold});
    if (m_chipselect && int'(m_address) >= DEPTH) cs_oor++;
  end

  // Called at a negedge; holds the request until a cycle with waitrequest low
  task automatic req(input bit rd, input bit wr, input int a, input logic [3:0] be,
                     input logic [31:0] d, input int lat);
    bit ok;
    ok = 1'b0;
    s_read = rd; s_write = wr; s_address = a[ADDR_W-1:0]; s_byteenable = be; s_writedata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!s_waitrequest) begin
        ok = 1'b1;
        if (wr) begin
          if (!out_of_range(a)) gold[a] = merge(gold_rd(a), d, be);
        end else if (rd) begin
          expq.push_back('{out_of_range(a) ? 32'hDEAD_BEEF : gold_rd(a), cyc, lat});
        end
      end
      @(negedge clk);
    end
    s_read = 1'b0; s_write = 1'b0;
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expq.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  bit running;
  int seen;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wait", {31'd0, s_waitrequest}, 32'd1);
    check("rst_rdv", {31'd0, s_readdatavalid}, 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    check("rst_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_err", {31'd0, err_sticky}, 32'd0);
    reset_n = 1'b1;
    #1 check("wait_at_release", {31'd0, s_waitrequest}, 32'd1);
    @(negedge clk);
    check("wait_after_release", {31'd0, s_waitrequest}, 32'd0);

    // write then read back, fixed 3-clk latency
    req(0, 1, 'h10, 4'hF, 32'hA5A5_1234, 0);
    req(1, 0, 'h10, 4'hF, 32'h0, 3);
    drain();

    // byte-lane write over zero
    req(0, 1, 'h20, 4'hF, 32'h0, 0);
    req(0, 1, 'h20, 4'b0010, 32'hFFFF_FFFF, 0);
    req(1, 0, 'h20, 4'hF, 32'h0, 3);
    drain();

    // hold fills the queue; 5th waits; release gives 5 back-to-back responses
    for (int i = 0; i < 5; i++) req(0, 1, 'h40 + i, 4'hF, 32'h1111_0000 + 32'(i), 0);
    drain();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) req(1, 0, 'h40 + i, 4'hF, 32'h0, 0);
    check("full_wait", {31'd0, s_waitrequest}, 32'd1);
    check("hold_cs", {31'd0, m_chipselect}, 32'd0);
    fork
      req(1, 0, 'h44, 4'hF, 32'h0, 0);
      begin
        repeat (3) @(negedge clk);
        check("still_full", {31'd0, s_waitrequest}, 32'd1);
        hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !s_readdatavalid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          if (s_readdatavalid) seen++;
          @(negedge clk);
        end
        check("b2b_count", 32'(seen), 32'd5);
      end
    join
    drain();

    // read+write together performs the write only
    req(1, 1, 'h30, 4'hF, 32'h1357_9BDF, 0);
    repeat (4) @(negedge clk);
    req(1, 0, 'h30, 4'hF, 32'h0, 3);
    drain();

`ifdef MCU_RAM_PIPE_RANGE_CHECK_EN
    req(1, 0, 'hC800, 4'hF, 32'h0, 3);
    drain();
    check("err_set", {31'd0, err_sticky}, 32'd1);
    req(0, 1, 'hC801, 4'hF, 32'h5555_AAAA, 0);
    drain();
`endif

    // randomized traffic with random hold
    running = 1'b1;
    fork
      while (running) begin
        @(negedge clk);
        hold = ($urandom_range(0, 3) == 0);
      end
      begin
        for (int n = 0; n < 300; n++) begin
          int op, a;
          op = $urandom_range(0, 9);
          a  = $urandom_range(0, 31);
`ifdef MCU_RAM_PIPE_RANGE_CHECK_EN
          if ($urandom_range(0, 15) == 0) a = DEPTH + $urandom_range(0, 100);
`endif
          req(op <= 4 || op == 9, op >= 5, a, 4'($urandom), $urandom, 0);
          if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        running = 1'b0;
      end
    join
    hold = 1'b0;
    drain();

    // reset with reads queued and in flight: all discarded
    for (int i = 0; i < 3; i++) req(1, 0, i, 4'hF, 32'h0, 0);
    #2 reset_n = 1'b0;
    #1 check("midrst_wait", {31'd0, s_waitrequest}, 32'd1);
    check("midrst_rdv", {31'd0, s_readdatavalid}, 32'd0);
    check("midrst_err", {31'd0, err_sticky}, 32'd0);
    expq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_release", {31'd0, s_waitrequest}, 32'd0);
    repeat (6) @(negedge clk);
    req(1, 0, 'h10, 4'hF, 32'h0, 3);
    drain();

    check("cs_out_of_range", 32'(cs_oor), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
